regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 wb_valid  input  1  pipeline writeback stage has a result this cycle.
REQ-005 wb_rd  input  5  pipeline writeback destination.
REQ-006 wb_data  input  32  pipeline writeback data.
REQ-007 lu_issue  input  1  decode issues an op to the long-latency unit (LU).
REQ-008 lu_issue_rd  input  5  destination register of the issued LU op.
REQ-009 lu_valid  input  1  LU result pending.
REQ-010 lu_rd  input  5  LU result destination.
REQ-011 lu_data  input  32  LU result data.
REQ-012 lu_ready  output  1  LU result accepted this cycle (valid/ready handshake).
REQ-013 raddr1, raddr2  input  5 each  decode-stage source registers.
REQ-014 rs1_used, rs2_used  input  1 each  source operand actually read.
REQ-015 dec_rd  input  5  decode-stage destination register.
REQ-016 dec_rd_used  input  1  decode instruction writes dec_rd.
REQ-017 stall_E  output  1  hold decode/fetch this cycle.
REQ-018 reg_wr_E  output  1  registered write enable to register file.
REQ-019 waddr  output  5  registered write address.
REQ-020 wdata  output  32  registered write data.

Function
REQ-021 Write port SHALL be shared: pipeline writeback has fixed priority over LU.
REQ-022 lu_ready SHALL be combinational: lu_valid && !(wb_valid && wb_rd!=0).
REQ-023 Each posedge: if wb_valid && wb_rd!=0 -> reg_wr_E=1, waddr=wb_rd, wdata=wb_data; else if lu_valid && lu_ready -> reg_wr_E=1, waddr=lu_rd, wdata=lu_data; else reg_wr_E=0, waddr/wdata hold.
REQ-024 Latency SHALL be exactly one cycle from accepted source to reg_wr_E.
REQ-025 Writes with destination 0 SHALL never assert reg_wr_E; an LU result with lu_rd=0 SHALL be accepted (lu_ready=1) and dropped.
REQ-026 Scoreboard: 32-bit busy vector; busy[0] SHALL be constant 0.
REQ-027 busy[r] SHALL set on posedge when lu_issue && lu_issue_rd==r && r!=0 && !stall_E.
REQ-028 busy[r] SHALL clear on posedge when LU result for r is accepted.
REQ-029 Same-cycle set and clear of same r: set SHALL win (bit stays 1).
REQ-030 stall_E SHALL be combinational OR of: rs1_used && busy[raddr1]; rs2_used && busy[raddr2]; dec_rd_used && busy[dec_rd] (WAW); lu_issue && busy[lu_issue_rd]; starve_force.
REQ-031 No forwarding: a source whose LU result is being written this cycle SHALL still stall (busy clears at the posedge).
REQ-032 Starvation counter starve_cnt (2-bit): increments (saturating at 3) each cycle lu_valid && !lu_ready; clears when lu_ready=1 or lu_valid=0.
REQ-033 starve_force SHALL be 1 while starve_cnt==3, inserting bubbles until the LU result is accepted.
REQ-034 LU SHALL hold lu_rd/lu_data stable while lu_valid && !lu_ready; scheduler SHALL not buffer LU results internally.

Reset
REQ-035 While rst=1 on a posedge: reg_wr_E=0, waddr=0, wdata=0, busy=0, starve_cnt=0.
REQ-036 Combinational outputs during reset cycle follow REQ-022/REQ-030 from cleared state; reset mid-operation SHALL discard all pending busy bits with no write issued.

Verification
REQ-037 wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle reg_wr_E=1, waddr=5, wdata=0xDEADBEEF.
REQ-038 wb_valid=1 rd=3 with lu_valid=1 rd=7 same cycle -> lu_ready=0, write to x3; next cycle wb_valid=0 -> lu_ready=1, x7 written one cycle later.
REQ-039 lu_issue rd=9; following cycle raddr1=9, rs1_used=1 -> stall_E=1 until LU result rd=9 accepted; stall_E=0 the cycle after.
REQ-040 wb_valid continuously 1 (rd!=0) with lu_valid=1 -> stall_E rises after 3 refused cycles; once wb_valid drops, lu_ready=1 and starve_cnt=0.
REQ-041 wb_rd=0 with wb_valid=1, lu_valid=1 rd=4 -> lu_ready=1, next cycle reg_wr_E=1 waddr=4; lu_rd=0 result -> accepted, reg_wr_E=0.
REQ-042 rst=1 with busy[9]=1 and starve_cnt=2 -> next cycle busy=0, reg_wr_E=0, stall_E=0 for raddr1=9.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback/LU/decode signal bundle for the writeback scheduler
interface regfile_wb_scheduler_if;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        lu_issue;
   logic [4:0]  lu_issue_rd;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic        rs1_used;
   logic        rs2_used;
   logic [4:0]  dec_rd;
   logic        dec_rd_used;
   logic        stall_E;
   logic        reg_wr_E;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   modport master (
      output wb_valid, wb_rd, wb_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
             raddr1, raddr2, rs1_used, rs2_used, dec_rd, dec_rd_used,
      input  lu_ready, stall_E, reg_wr_E, waddr, wdata
   );
   modport slave (
      input  wb_valid, wb_rd, wb_data, lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
             raddr1, raddr2, rs1_used, rs2_used, dec_rd, dec_rd_used,
      output lu_ready, stall_E, reg_wr_E, waddr, wdata
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between writeback and LU, tracks LU hazards
module regfile_wb_scheduler (
   input logic clk,
   input logic rst,
   regfile_wb_scheduler_if.slave bus
);
   logic [31:0] busy;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;
   logic [1:0]  starve_cnt;
   logic        wb_take;
   logic        starve_force;
   // write-port arbitration (writeback wins), hazard stall and busy update masks
   always_comb begin
      wb_take = bus.wb_valid && bus.wb_rd != 5'd0;
      bus.lu_ready = bus.lu_valid && !wb_take;
      starve_force = starve_cnt == 2'd3;
      bus.stall_E = (bus.rs1_used && busy[bus.raddr1]) || (bus.rs2_used && busy[bus.raddr2]) ||
                    (bus.dec_rd_used && busy[bus.dec_rd]) || (bus.lu_issue && busy[bus.lu_issue_rd]) ||
                    starve_force;
      set_mask = (bus.lu_issue && !bus.stall_E) ? 32'd1 << bus.lu_issue_rd : 32'd0;
      clr_mask = bus.lu_ready ? 32'd1 << bus.lu_rd : 32'd0;
   end
   // scoreboard and starvation counter; a set applied after the clear so it wins on the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 32'd0;
         starve_cnt <= 2'd0;
      end else begin
         busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
         starve_cnt <= (bus.lu_valid && !bus.lu_ready) ? (starve_force ? 2'd3 : starve_cnt + 2'd1) : 2'd0;
      end
   end
   // registered write port; LU results for x0 are accepted but produce no write
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.reg_wr_E <= 1'b0;
         bus.waddr <= 5'd0;
         bus.wdata <= 32'd0;
      end else if (wb_take) begin
         bus.reg_wr_E <= 1'b1;
         bus.waddr <= bus.wb_rd;
         bus.wdata <= bus.wb_data;
      end else if (bus.lu_ready && bus.lu_rd != 5'd0) begin
         bus.reg_wr_E <= 1'b1;
         bus.waddr <= bus.lu_rd;
         bus.wdata <= bus.lu_data;
      end else begin
         bus.reg_wr_E <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: scoreboard bench for the writeback scheduler
module tb_regfile_wb_scheduler;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   regfile_wb_scheduler_if bus();
   regfile_wb_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] m_busy = 32'd0;
   logic [1:0]  m_cnt = 2'd0;
   logic        last_refused = 1'b0;
   logic [36:0] exp_q[$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.lu_issue = 0; bus.lu_issue_rd = 0;
      bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
      bus.raddr1 = 0; bus.raddr2 = 0; bus.rs1_used = 0; bus.rs2_used = 0;
      bus.dec_rd = 0; bus.dec_rd_used = 0;
   endtask
   task automatic cycle();
      logic wb_take, ready, stall, r;
      logic [36:0] e;
      #1;
      r = rst;
      wb_take = bus.wb_valid && bus.wb_rd != 0;
      ready = bus.lu_valid && !wb_take;
      stall = (bus.rs1_used && m_busy[bus.raddr1]) || (bus.rs2_used && m_busy[bus.raddr2]) ||
              (bus.dec_rd_used && m_busy[bus.dec_rd]) || (bus.lu_issue && m_busy[bus.lu_issue_rd]) ||
              m_cnt == 2'd3;
      check("lu_ready", {31'd0, bus.lu_ready}, {31'd0, ready});
      check("stall_E", {31'd0, bus.stall_E}, {31'd0, stall});
      last_refused = bus.lu_valid && !ready;
      if (r) begin
         m_busy = 32'd0;
         m_cnt = 2'd0;
         exp_q.delete();
      end else begin
         if (wb_take) exp_q.push_back({bus.wb_rd, bus.wb_data});
         else if (ready && bus.lu_rd != 0) exp_q.push_back({bus.lu_rd, bus.lu_data});
         if (ready) m_busy[bus.lu_rd] = 1'b0;
         if (bus.lu_issue && !stall) m_busy[bus.lu_issue_rd] = 1'b1;
         m_busy[0] = 1'b0;
         m_cnt = (bus.lu_valid && !ready) ? (m_cnt == 2'd3 ? 2'd3 : m_cnt + 2'd1) : 2'd0;
      end
      @(posedge clk);
      #1;
      check("reg_wr_E", {31'd0, bus.reg_wr_E}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("waddr", {27'd0, bus.waddr}, {27'd0, e[36:32]});
         check("wdata", bus.wdata, e[31:0]);
      end
      if (r) begin
         check("rst_waddr", {27'd0, bus.waddr}, 32'd0);
         check("rst_wdata", bus.wdata, 32'd0);
      end
   endtask
   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      // single writeback
      bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
      cycle();
      check("wb_waddr", {27'd0, bus.waddr}, 32'd5);
      // writeback and LU collide, LU waits one cycle
      bus.wb_rd = 3; bus.wb_data = 32'h33; bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 32'h77;
      cycle();
      bus.wb_valid = 0;
      cycle();
      check("lu_waddr", {27'd0, bus.waddr}, 32'd7);
      idle();
      // RAW hazard on x9 until its LU result is accepted
      bus.lu_issue = 1; bus.lu_issue_rd = 9;
      cycle();
      idle();
      bus.raddr1 = 9; bus.rs1_used = 1;
      cycle();
      check("raw_stall", {31'd0, bus.stall_E}, 32'd1);
      cycle();
      bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h99;
      cycle();
      bus.lu_valid = 0;
      cycle();
      idle();
      // starvation: writeback keeps winning, forced bubble after three refusals
      bus.wb_valid = 1; bus.wb_rd = 2; bus.wb_data = 32'h22;
      bus.lu_valid = 1; bus.lu_rd = 6; bus.lu_data = 32'h66;
      for (int i = 0; i < 4; i++) cycle();
      check("starve_stall", {31'd0, bus.stall_E}, 32'd1);
      bus.wb_valid = 0;
      cycle();
      bus.lu_valid = 0;
      cycle();
      idle();
      // x0 writeback lets LU through; LU result for x0 is dropped
      bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h1;
      bus.lu_valid = 1; bus.lu_rd = 4; bus.lu_data = 32'h44;
      cycle();
      bus.lu_rd = 0; bus.lu_data = 32'h55;
      cycle();
      idle();
      cycle();
      // reset mid-operation discards busy bits and starvation state
      bus.lu_issue = 1; bus.lu_issue_rd = 9;
      cycle();
      idle();
      bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h11;
      bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h9;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      idle();
      bus.raddr1 = 9; bus.rs1_used = 1;
      cycle();
      check("post_rst_stall", {31'd0, bus.stall_E}, 32'd0);
      // random traffic with LU holding its result while refused
      for (int i = 0; i < 400; i++) begin
         bus.wb_valid = $urandom_range(0, 2) == 0;
         bus.wb_rd = 5'($urandom_range(0, 7));
         bus.wb_data = $urandom();
         bus.lu_issue = $urandom_range(0, 3) == 0;
         bus.lu_issue_rd = 5'($urandom_range(0, 7));
         if (!last_refused) begin
            bus.lu_valid = $urandom_range(0, 2) == 0;
            bus.lu_rd = 5'($urandom_range(0, 7));
            bus.lu_data = $urandom();
         end
         bus.raddr1 = 5'($urandom_range(0, 7));
         bus.raddr2 = 5'($urandom_range(0, 7));
         bus.rs1_used = 1'($urandom_range(0, 1));
         bus.rs2_used = 1'($urandom_range(0, 1));
         bus.dec_rd = 5'($urandom_range(0, 7));
         bus.dec_rd_used = 1'($urandom_range(0, 1));
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
